// File: rtl/pll_scan_reconfig.sv
// PLL scan-chain reconfiguration responder: shadows the M/C0 high/low counts
// and serialises them onto the scan chain, then pulses configupdate.
module pll_scan_reconfig #(
    parameter logic [8:0] M_HIGH_DEF  = 9'd4,
    parameter logic [8:0] M_LOW_DEF   = 9'd4,
    parameter logic [8:0] C0_HIGH_DEF = 9'd2,
    parameter logic [8:0] C0_LOW_DEF  = 9'd2
) (
    input  logic       clock_ctr,
    input  logic       sys_reset,
    input  logic       reset_ctr,
    input  logic [3:0] counter_type,
    input  logic [2:0] counter_param,
    input  logic [8:0] config_data_in,
    input  logic       write_param,
    input  logic       read_param,
    input  logic       reconfig,
    output logic       busy,
    output logic [8:0] data_out,
    output logic       scanclk,
    output logic       scandata,
    output logic       scanclkena,
    output logic       configupdate
);

    localparam int unsigned CW   = 9;
    localparam int unsigned NREG = 4;
    localparam int unsigned SRW  = NREG * CW;
    localparam int unsigned BW   = 6;

    // Register file order matches scan order: M_high, M_low, C0_high, C0_low
    localparam logic [CW-1:0] REG_DEF [NREG] = '{M_HIGH_DEF, M_LOW_DEF, C0_HIGH_DEF, C0_LOW_DEF};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_UPDATE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   regs_q [NREG];
    logic [CW-1:0]   regs_d [NREG];
    logic [SRW-1:0]  sr_q, sr_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            phase_q, phase_d;
    logic            busy_d, scanclk_d, scandata_d, scanclkena_d, configupdate_d;
    logic [CW-1:0]   data_out_d;
    logic            sel_valid;
    logic [1:0]      sel_idx;

    // Decode counter_type/counter_param into a register index
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 2'd0;
        case (counter_type)
            4'b0001: begin
                sel_valid = (counter_param == 3'b000) || (counter_param == 3'b001);
                sel_idx   = {1'b0, counter_param[0]};
            end
            4'b0000: begin
                sel_valid = (counter_param == 3'b000) || (counter_param == 3'b001);
                sel_idx   = {1'b1, counter_param[0]};
            end
            default: begin
                sel_valid = 1'b0;
                sel_idx   = 2'd0;
            end
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        regs_d         = regs_q;
        sr_d           = sr_q;
        bit_cnt_d      = bit_cnt_q;
        phase_d        = phase_q;
        busy_d         = busy;
        data_out_d     = data_out;
        scanclk_d      = scanclk;
        scandata_d     = scandata;
        scanclkena_d   = scanclkena;
        configupdate_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (write_param && sel_valid) begin
                    regs_d[sel_idx] = config_data_in;
                end
                if (read_param) begin
                    data_out_d = sel_valid ? regs_q[sel_idx] : '0;
                end
                if (reconfig) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                sr_d         = {regs_q[0], regs_q[1], regs_q[2], regs_q[3]};
                bit_cnt_d    = BW'(SRW - 1);
                phase_d      = 1'b0;
                scanclk_d    = 1'b0;
                scandata_d   = regs_q[0][CW-1];
                scanclkena_d = 1'b1;
                state_d      = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!phase_q) begin
                    scanclk_d = 1'b1;
                    phase_d   = 1'b1;
                end else if (bit_cnt_q == '0) begin
                    scanclk_d      = 1'b0;
                    scanclkena_d   = 1'b0;
                    configupdate_d = 1'b1;
                    state_d        = ST_UPDATE;
                end else begin
                    // Next bit is presented while scanclk is low so it is stable at the rise
                    sr_d       = {sr_q[SRW-2:0], 1'b0};
                    scandata_d = sr_q[SRW-2];
                    bit_cnt_d  = bit_cnt_q - BW'(1);
                    phase_d    = 1'b0;
                    scanclk_d  = 1'b0;
                end
            end
            ST_UPDATE: begin
                scandata_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Soft reset wins over every other input
        if (reset_ctr) begin
            state_d        = ST_IDLE;
            regs_d         = REG_DEF;
            sr_d           = '0;
            bit_cnt_d      = '0;
            phase_d        = 1'b0;
            busy_d         = 1'b0;
            data_out_d     = '0;
            scanclk_d      = 1'b0;
            scandata_d     = 1'b0;
            scanclkena_d   = 1'b0;
            configupdate_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clock_ctr or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= REG_DEF[i];
            end
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            phase_q      <= 1'b0;
            busy         <= 1'b0;
            data_out     <= '0;
            scanclk      <= 1'b0;
            scandata     <= 1'b0;
            scanclkena   <= 1'b0;
            configupdate <= 1'b0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            phase_q      <= phase_d;
            busy         <= busy_d;
            data_out     <= data_out_d;
            scanclk      <= scanclk_d;
            scandata     <= scandata_d;
            scanclkena   <= scanclkena_d;
            configupdate <= configupdate_d;
        end
    end

endmodule

// File: tb/tb_pll_scan_reconfig.sv
// Directed bench for pll_scan_reconfig with a register model and scoreboard
// queues for readback values and scan bits.
module tb_pll_scan_reconfig;

    logic       clock_ctr = 1'b0;
    logic       sys_reset = 1'b0;
    logic       reset_ctr = 1'b0;
    logic [3:0] counter_type = 4'd0;
    logic [2:0] counter_param = 3'd0;
    logic [8:0] config_data_in = 9'd0;
    logic       write_param = 1'b0;
    logic       read_param = 1'b0;
    logic       reconfig = 1'b0;
    logic       busy;
    logic [8:0] data_out;
    logic       scanclk, scandata, scanclkena, configupdate;

    pll_scan_reconfig dut (
        .clock_ctr      (clock_ctr),
        .sys_reset      (sys_reset),
        .reset_ctr      (reset_ctr),
        .counter_type   (counter_type),
        .counter_param  (counter_param),
        .config_data_in (config_data_in),
        .write_param    (write_param),
        .read_param     (read_param),
        .reconfig       (reconfig),
        .busy           (busy),
        .data_out       (data_out),
        .scanclk        (scanclk),
        .scandata       (scandata),
        .scanclkena     (scanclkena),
        .configupdate   (configupdate)
    );

    always #5 clock_ctr = ~clock_ctr;

    int vectors = 0;
    int miscompares = 0;

    // Reference model of the register file
    logic [8:0] m_h = 9'd4, m_l = 9'd4, c0_h = 9'd2, c0_l = 9'd2;

    logic [8:0] exp_rd [$];
    logic       exp_bits [$];

    int          scan_rises = 0, cu_pulses = 0, cu_cycles = 0, busy_cycles = 0;
    int          cyc = 0, busy_rise = 0, cu_rise = 0;
    logic        busy_p = 1'b0, cu_p = 1'b0;
    logic [35:0] cap = '0;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scan scoreboard: each scanclk rise pops one expected bit
    always @(posedge scanclk) begin
        logic eb;
        scan_rises++;
        cap = {cap[34:0], scandata};
        eb  = (exp_bits.size() != 0) ? exp_bits.pop_front() : 1'bx;
        vectors++;
        assert (scandata === eb) else begin
            miscompares++;
            $error("FAIL scan_bit%0d observed=%0b expected=%0b", scan_rises, scandata, eb);
        end
    end

    always @(negedge clock_ctr) begin
        cyc++;
        if (busy === 1'b1) busy_cycles++;
        if (busy === 1'b1 && busy_p !== 1'b1) busy_rise = cyc;
        if (configupdate === 1'b1) cu_cycles++;
        if (configupdate === 1'b1 && cu_p !== 1'b1) begin
            cu_pulses++;
            cu_rise = cyc;
        end
        busy_p = busy;
        cu_p   = configupdate;
    end

    task automatic tick();
        @(posedge clock_ctr);
        #1;
    endtask

    function automatic logic [8:0] model_rd(input logic [3:0] t, input logic [2:0] p);
        if (t == 4'b0001 && p == 3'b000) return m_h;
        if (t == 4'b0001 && p == 3'b001) return m_l;
        if (t == 4'b0000 && p == 3'b000) return c0_h;
        if (t == 4'b0000 && p == 3'b001) return c0_l;
        return 9'd0;
    endfunction

    function automatic void model_wr(input logic [3:0] t, input logic [2:0] p, input logic [8:0] d);
        if (t == 4'b0001 && p == 3'b000) m_h = d;
        if (t == 4'b0001 && p == 3'b001) m_l = d;
        if (t == 4'b0000 && p == 3'b000) c0_h = d;
        if (t == 4'b0000 && p == 3'b001) c0_l = d;
    endfunction

    function automatic void model_defaults();
        m_h = 9'd4; m_l = 9'd4; c0_h = 9'd2; c0_l = 9'd2;
    endfunction

    function automatic void push_scan();
        logic [35:0] w;
        w = {m_h, m_l, c0_h, c0_l};
        for (int i = 35; i >= 0; i--) exp_bits.push_back(w[i]);
    endfunction

    function automatic void clr_mon();
        scan_rises = 0; cu_pulses = 0; cu_cycles = 0; busy_cycles = 0; cap = '0;
    endfunction

    task automatic wr(input logic [3:0] t, input logic [2:0] p, input logic [8:0] d);
        counter_type = t; counter_param = p; config_data_in = d; write_param = 1'b1;
        model_wr(t, p, d);
        tick();
        write_param = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] t, input logic [2:0] p);
        counter_type = t; counter_param = p; read_param = 1'b1;
        exp_rd.push_back(model_rd(t, p));
        tick();
        read_param = 1'b0;
        chk(tag, 36'(data_out), 36'(exp_rd.pop_front()));
    endtask

    task automatic pulse_reconfig();
        reconfig = 1'b1;
        tick();
        reconfig = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy === 1'b1; i++) tick();
        chk("busy_timeout", 36'(busy), 36'd0);
    endtask

    task automatic wait_rises(input int n);
        for (int i = 0; i < 300 && scan_rises < n; i++) tick();
        chk("rise_timeout", 36'(scan_rises), 36'(n));
    endtask

    initial begin
        // Power-on reset
        tick();
        tick();
        sys_reset = 1'b1;
        tick();
        chk("rst_busy", 36'(busy), 36'd0);
        chk("rst_dout", 36'(data_out), 36'd0);
        chk("rst_scan", 36'({scanclk, scandata, scanclkena, configupdate}), 36'd0);
        rd("def_mh", 4'b0001, 3'b000);
        rd("def_ml", 4'b0001, 3'b001);
        rd("def_ch", 4'b0000, 3'b000);
        rd("def_cl", 4'b0000, 3'b001);

        // Write / readback, invalid pairs
        wr(4'b0001, 3'b000, 9'h1A5);
        wr(4'b0000, 3'b001, 9'h003);
        wr(4'b0010, 3'b000, 9'h0FF);
        wr(4'b0001, 3'b101, 9'h0FF);
        rd("rd_mh", 4'b0001, 3'b000);
        rd("rd_cl", 4'b0000, 3'b001);
        rd("rd_bad_type", 4'b0010, 3'b000);
        rd("rd_ml", 4'b0001, 3'b001);
        rd("rd_ch", 4'b0000, 3'b000);
        rd("rd_bad_param", 4'b0000, 3'b011);
        rd("rd_mh2", 4'b0001, 3'b000);
        tick();
        tick();
        chk("dout_hold", 36'(data_out), 36'(m_h));

        // Scan order and timing
        wr(4'b0001, 3'b000, 9'h101);
        wr(4'b0001, 3'b001, 9'h002);
        wr(4'b0000, 3'b000, 9'h004);
        wr(4'b0000, 3'b001, 9'h080);
        clr_mon();
        push_scan();
        pulse_reconfig();
        chk("busy_rise", 36'(busy), 36'd1);
        wait_idle();
        tick();
        chk("scan_word", cap, {m_h, m_l, c0_h, c0_l});
        chk("scan_rises", 36'(scan_rises), 36'd36);
        chk("cu_pulses", 36'(cu_pulses), 36'd1);
        chk("cu_width", 36'(cu_cycles), 36'd1);
        chk("cu_delay", 36'(cu_rise - busy_rise), 36'd73);
        chk("busy_len", 36'(busy_cycles), 36'd74);
        chk("scan_q_empty", 36'(exp_bits.size()), 36'd0);

        // Busy lockout: write and reconfig during Shift are dropped
        clr_mon();
        push_scan();
        pulse_reconfig();
        wait_rises(5);
        counter_type = 4'b0001; counter_param = 3'b000; config_data_in = 9'h0AA;
        write_param = 1'b1; reconfig = 1'b1; read_param = 1'b1;
        tick();
        write_param = 1'b0; reconfig = 1'b0; read_param = 1'b0;
        wait_idle();
        tick();
        tick();
        chk("lock_busy", 36'(busy), 36'd0);
        chk("lock_cu", 36'(cu_pulses), 36'd1);
        chk("lock_rises", 36'(scan_rises), 36'd36);
        rd("lock_mh", 4'b0001, 3'b000);

        // Simultaneous write + reconfig: new value is shifted
        clr_mon();
        counter_type = 4'b0000; counter_param = 3'b001; config_data_in = 9'h1FF;
        write_param = 1'b1; reconfig = 1'b1;
        model_wr(4'b0000, 3'b001, 9'h1FF);
        push_scan();
        tick();
        write_param = 1'b0; reconfig = 1'b0;
        wait_idle();
        tick();
        chk("simul_last9", 36'(cap[8:0]), 36'h1FF);
        chk("simul_word", cap, {m_h, m_l, c0_h, c0_l});

        // Soft-reset abort mid-shift
        clr_mon();
        push_scan();
        pulse_reconfig();
        wait_rises(10);
        reset_ctr = 1'b1;
        tick();
        reset_ctr = 1'b0;
        exp_bits.delete();
        model_defaults();
        chk("abort_busy", 36'(busy), 36'd0);
        chk("abort_ena", 36'(scanclkena), 36'd0);
        for (int i = 0; i < 80; i++) tick();
        chk("abort_cu", 36'(cu_pulses), 36'd0);
        chk("abort_rises", 36'(scan_rises), 36'd10);
        rd("abort_mh", 4'b0001, 3'b000);
        rd("abort_ml", 4'b0001, 3'b001);
        rd("abort_ch", 4'b0000, 3'b000);
        rd("abort_cl", 4'b0000, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
